// File: rtl/multiplier_32_unsign_seq.sv
// Sequential shift-and-add unsigned multiplier with valid/ready handshakes on both sides.
// Optional macro MULT_EARLY_EXIT_EN ends the run as soon as the remaining multiplier bits are zero.
module multiplier_32_unsign_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state, state_next;
    logic [2*WIDTH-1:0]  mcand;
    logic [2*WIDTH-1:0]  acc;
    logic [WIDTH-1:0]    mplier;
    logic [CW-1:0]       count;

    logic [2*WIDTH-1:0]  acc_sum;
    logic [WIDTH-1:0]    mplier_shr;
    logic [CW-1:0]       count_inc;
    logic                finish;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_sum    = acc + (mplier[0] ? mcand : '0);
        mplier_shr = {1'b0, mplier[WIDTH-1:1]};
        count_inc  = count + CW'(1);
        unique case (state)
            IDLE: if (in_valid) state_next = RUN;
            RUN: begin
                if (count_inc == CW'(WIDTH)) state_next = DONE;
`ifdef MULT_EARLY_EXIT_EN
                if (mplier_shr == '0) state_next = DONE;
`endif
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        finish = (state == RUN) && (state_next == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
            p      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= mplier_shr;
                    count  <= count_inc;
                    // Product is captured from the final partial sum, not acc, to save an edge.
                    if (finish) p <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multiplier_32_unsign_seq.md
MULTIPLIER_32_UNSIGN_SEQ -- requirements
Module: multiplier_32_unsign_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  sole clock, all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operands a/b present.
REQ-005 SHALL have port in_ready  output  1  block accepts operands; equals (state==IDLE).
REQ-006 SHALL have port a  input  WIDTH  unsigned multiplicand.
REQ-007 SHALL have port b  input  WIDTH  unsigned multiplier.
REQ-008 SHALL have port out_valid  output  1  product p valid; equals (state==DONE).
REQ-009 SHALL have port out_ready  input  1  consumer takes p.
REQ-010 SHALL have port p  output  2*WIDTH  unsigned product a*b, registered.

Function
REQ-011 SHALL implement FSM IDLE, RUN, DONE; operand accept when in_valid & in_ready at a rising edge (edge T0).
REQ-012 On accept SHALL load mcand = zero-extended a (2*WIDTH), mplier = b, acc = 0, count = 0, and go to RUN; a/b ignored afterwards.
REQ-013 Each RUN edge SHALL: acc += mcand if mplier[0]; mcand <<= 1; mplier >>= 1; count += 1.
REQ-014 RUN SHALL go to DONE on the edge where count reaches WIDTH (without MULT_EARLY_EXIT_EN), i.e. out_valid first high after edge T0+WIDTH.
REQ-015 On RUN->DONE edge p SHALL load the final acc; p SHALL be stable while out_valid is high.
REQ-016 DONE SHALL hold out_valid and p until out_valid & out_ready at an edge, then go to IDLE.
REQ-017 in_ready SHALL be low in RUN and DONE; no new operands overlap an operation; earliest next accept is the edge after the out handshake.
REQ-018 Arithmetic SHALL be exact modulo-free: p == a*b for all 2^(2*WIDTH) operand pairs; no overflow possible in 2*WIDTH bits.
REQ-019 in_valid and out_ready SHALL be ignored in states where they have no handshake meaning.
REQ-020 p SHALL retain its last value in IDLE and RUN until overwritten per REQ-015.

Reset
REQ-021 reset_n low SHALL immediately force state=IDLE, p=0, acc=0, mcand=0, mplier=0, count=0, hence out_valid=0, in_ready=1.
REQ-022 Reset asserted mid-RUN or in DONE SHALL abort the operation with no out_valid pulse; first accept possible on the first edge after reset_n rises.

Configuration
REQ-023 Macro MULT_EARLY_EXIT_EN defined: RUN SHALL also go to DONE on the edge where the shifted mplier becomes zero, so latency = max(1, k+1) edges for highest set bit k of b (b=0 gives 1).
REQ-024 Macro MULT_EARLY_EXIT_EN undefined: latency SHALL be fixed at WIDTH edges for all operands; p results identical in both builds.

Verification
REQ-025 Reset, then a=7, b=6, in_valid=1 one cycle, out_ready=1 -> out_valid high after edge T0+32 (default build) for exactly one cycle, p=42, in_ready=1 next cycle.
REQ-026 a=32'hFFFFFFFF, b=32'hFFFFFFFF -> p=64'hFFFFFFFE00000001; a=0 or b=0 -> p=0.
REQ-027 out_ready=0 for 10 cycles after out_valid -> out_valid and p held constant, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-028 reset_n pulsed low at T0+10 during RUN -> out_valid never rises for that operation, p=0, in_ready=1; next a=3, b=5 gives p=15.
REQ-029 With MULT_EARLY_EXIT_EN: b=1 -> out_valid after T0+1; b=0 -> T0+1; b=32'h80000000 -> T0+32; a=9, b=4 -> T0+3, p=36.
REQ-030 10,000 random back-to-back operand pairs with random out_ready stalls -> every p matches reference a*b, no lost or duplicated results.
